// File: rtl/gamma_mem.sv
// ---------------------------------------------------------------------------
// gamma_mem
// Storage responder for the MAP decoder's gamma branch-metric buffer. It sits
// on the far end of the gamma controller's w_r_gn/gn_addr interface, captures
// one frame of four branch metrics per trellis step during the write phase and
// returns them with a fixed 1-cycle read latency to the alpha/beta units.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   w_r_gn     in   1 = write phase, 0 = read phase
//   gn_addr    in   [AW-1:0] entry address from the gamma controller
//   gm_in      in   [4*DW-1:0] write data {g11,g10,g01,g00}
//   gm_out     out  [4*DW-1:0] registered read data
//   rd_valid   out  gm_out holds a valid, in-range, written entry this cycle
//   rd_addr_q  out  [AW-1:0] address associated with the current gm_out
//   frame_full out  every entry of the current frame has been written
//   drained    out  DEPTH valid reads completed; held until the next frame
//   addr_err   out  sticky out-of-range access flag for the current frame
//
// Optional feature macro: GAMMA_REV_READ_EN
//   When defined, read-phase addresses are mirrored (DEPTH-1-gn_addr) so the
//   beta recursion walks the trellis backwards; rd_addr_q reports the mirrored
//   (physical) address. Range checks always use the raw gn_addr.
// ---------------------------------------------------------------------------
module gamma_mem #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_r_gn,
    input  logic [AW-1:0]   gn_addr,
    input  logic [4*DW-1:0] gm_in,
    output logic [4*DW-1:0] gm_out,
    output logic            rd_valid,
    output logic [AW-1:0]   rd_addr_q,
    output logic            frame_full,
    output logic            drained,
    output logic            addr_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        HOLD
    } state_t;

    state_t            state;
    logic [4*DW-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [CW-1:0]     rd_cnt;

    logic              in_range;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [DEPTH-1:0]  wr_bit;
    logic              do_write;
    logic              do_read;
    logic              new_frame;

    assign in_range = (gn_addr < AW'(DEPTH));
    assign wr_idx   = gn_addr[IW-1:0];

`ifdef GAMMA_REV_READ_EN
    // Mirror the read address so the frame comes back last-step-first.
    assign rd_idx = IW'(DEPTH - 1) - gn_addr[IW-1:0];
`else
    assign rd_idx = gn_addr[IW-1:0];
`endif

    assign wr_bit = in_range ? (DEPTH'(1) << wr_idx) : '0;

    // A write phase cycle writes in every state; coming from DRAIN or HOLD it
    // additionally opens a new frame. A write always wins over a read.
    assign do_write  = (w_r_gn == 1'b1);
    assign new_frame = do_write && ((state == DRAIN) || (state == HOLD));
    assign do_read   = (w_r_gn == 1'b0) && ((state == FILL) || (state == DRAIN));

    // Metric storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst && do_write && in_range) begin
            mem[wr_idx] <= gm_in;
        end
    end

    // Frame control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            rd_cnt     <= '0;
            gm_out     <= '0;
            rd_valid   <= 1'b0;
            rd_addr_q  <= '0;
            frame_full <= 1'b0;
            drained    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            // frame_full lags the completing write by one cycle on purpose.
            frame_full <= &valid;

            if (do_write) begin
                state    <= FILL;
                valid    <= (new_frame ? {DEPTH{1'b0}} : valid) | wr_bit;
                addr_err <= (new_frame ? 1'b0 : addr_err) | !in_range;
                if (new_frame) begin
                    rd_cnt     <= '0;
                    drained    <= 1'b0;
                    frame_full <= 1'b0;
                end
            end else if (do_read) begin
                state     <= DRAIN;
                rd_addr_q <= in_range ? AW'(rd_idx) : gn_addr;
                if (in_range && valid[rd_idx]) begin
                    gm_out   <= mem[rd_idx];
                    rd_valid <= 1'b1;
                    rd_cnt   <= rd_cnt + CW'(1);
                    // drained rises together with the final valid read.
                    if (rd_cnt == CW'(DEPTH - 1)) begin
                        state   <= HOLD;
                        drained <= 1'b1;
                    end
                end else begin
                    gm_out <= '0;
                    if (!in_range) begin
                        addr_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gamma_mem.sv
// ---------------------------------------------------------------------------
// tb_gamma_mem
// Self-checking bench for gamma_mem: directed frames from the test plan plus
// randomized frames, all compared against a behavioural frame model.
// ---------------------------------------------------------------------------
module tb_gamma_mem;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AW    = 8;

`ifdef GAMMA_REV_READ_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            w_r_gn;
    logic [AW-1:0]   gn_addr;
    logic [4*DW-1:0] gm_in;
    logic [4*DW-1:0] gm_out;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr_q;
    logic            frame_full;
    logic            drained;
    logic            addr_err;

    int checks = 0;
    int errors = 0;

    gamma_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_r_gn     (w_r_gn),
        .gn_addr    (gn_addr),
        .gm_in      (gm_in),
        .gm_out     (gm_out),
        .rd_valid   (rd_valid),
        .rd_addr_q  (rd_addr_q),
        .frame_full (frame_full),
        .drained    (drained),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural frame model: phase 0 = idle, 1 = writing, 2 = reading,
    // 3 = frame fully consumed.
    int          m_phase;
    int          m_reads;
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];
    logic [31:0] m_gm_out;
    bit          m_rd_valid;
    int          m_rd_addr;
    bit          m_frame_full;
    bit          m_drained;
    bit          m_addr_err;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit w, input int addr, input logic [31:0] d);
        bit inr;
        bit all_valid;
        int phys;
        inr = (addr < DEPTH);
        all_valid = 1'b1;
        foreach (m_valid[i]) if (!m_valid[i]) all_valid = 1'b0;
        if (!r) begin
            m_phase = 0; m_reads = 0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_gm_out = 0; m_rd_valid = 0; m_rd_addr = 0;
            m_frame_full = 0; m_drained = 0; m_addr_err = 0;
            return;
        end
        m_rd_valid   = 1'b0;
        m_frame_full = all_valid;
        if (w) begin
            if (m_phase >= 2) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_frame_full = 0; m_drained = 0; m_addr_err = 0; m_reads = 0;
            end
            m_phase = 1;
            if (inr) begin
                m_mem[addr]   = d;
                m_valid[addr] = 1'b1;
            end else begin
                m_addr_err = 1'b1;
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            m_phase = 2;
            phys = REV ? (DEPTH - 1 - addr) : addr;
            m_rd_addr = inr ? phys : addr;
            if (inr && m_valid[phys]) begin
                m_gm_out   = m_mem[phys];
                m_rd_valid = 1'b1;
                m_reads++;
                if (m_reads == DEPTH) begin
                    m_phase   = 3;
                    m_drained = 1'b1;
                end
            end else begin
                m_gm_out = 0;
                if (!inr) m_addr_err = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model and compares every output
    // 1 ns after the active edge.
    task automatic applyStimulus(input bit r, input bit w, input int addr, input logic [31:0] d);
        rst     = r;
        w_r_gn  = w;
        gn_addr = AW'(addr);
        gm_in   = d;
        @(posedge clk);
        modelStep(r, w, addr, d);
        #1;
        checkOutput("gm_out",     64'(gm_out),     64'(m_gm_out));
        checkOutput("rd_valid",   64'(rd_valid),   64'(m_rd_valid));
        checkOutput("rd_addr_q",  64'(rd_addr_q),  64'(m_rd_addr));
        checkOutput("frame_full", 64'(frame_full), 64'(m_frame_full));
        checkOutput("drained",    64'(drained),    64'(m_drained));
        checkOutput("addr_err",   64'(addr_err),   64'(m_addr_err));
    endtask

    initial begin
        int phys;
        int nw;
        int nr;
        rst = 1'b0; w_r_gn = 1'b0; gn_addr = '0; gm_in = '0;
        #1;

        // Reset state
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 3, 32'hDEAD_BEEF);
        checkOutput("reset_gm_out", 64'(gm_out), 64'h0);
        checkOutput("reset_flags", 64'({rd_valid, frame_full, drained, addr_err}), 64'h0);

        // Idle ignores read-phase traffic
        applyStimulus(1, 0, 2, 0);
        checkOutput("idle_rd_valid", 64'(rd_valid), 64'h0);

        // Nominal frame with one-address overshoot in each phase
        for (int a = 0; a <= DEPTH; a++) begin
            applyStimulus(1, 1, a, 32'h0A0B_0C00 + a);
            if (a == DEPTH - 1) checkOutput("ff_delayed", 64'(frame_full), 64'h0);
            if (a == DEPTH) begin
                checkOutput("ff_nominal", 64'(frame_full), 64'h1);
                checkOutput("err_wr_overshoot", 64'(addr_err), 64'h1);
            end
        end
        for (int k = 0; k <= DEPTH; k++) begin
            applyStimulus(1, 0, k, 0);
            if (k < DEPTH) begin
                phys = REV ? (DEPTH - 1 - k) : k;
                checkOutput("nom_data", 64'(gm_out), 64'(32'h0A0B_0C00 + phys));
                checkOutput("nom_valid", 64'(rd_valid), 64'h1);
                checkOutput("nom_addr", 64'(rd_addr_q), 64'(phys));
            end
            if (k == DEPTH - 1) checkOutput("nom_drained", 64'(drained), 64'h1);
            if (k == DEPTH) checkOutput("nom_overshoot_valid", 64'(rd_valid), 64'h0);
        end

        // Back-to-back frame from HOLD
        applyStimulus(1, 1, 0, 32'h0000_00FF);
        checkOutput("b2b_drained", 64'(drained), 64'h0);
        checkOutput("b2b_err", 64'(addr_err), 64'h0);
        applyStimulus(1, 0, 1, 0);
        checkOutput("b2b_rd1_valid", 64'(rd_valid), 64'h0);

        // Partial fill with overwrite of address 3
        for (int a = 0; a < 6; a++) begin
            if (a == 3) applyStimulus(1, 1, 3, 32'h1111_1111);
            applyStimulus(1, 1, a, (a == 3) ? 32'h2222_2222 : 32'h5000_0000 + a);
        end
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1, 0, k, 0);
            phys = REV ? (DEPTH - 1 - k) : k;
            if (phys >= 6) begin
                checkOutput("part_unwritten_data", 64'(gm_out), 64'h0);
                checkOutput("part_unwritten_valid", 64'(rd_valid), 64'h0);
            end
            if (phys == 3) checkOutput("overwrite_data", 64'(gm_out), 64'h2222_2222);
        end
        checkOutput("part_drained", 64'(drained), 64'h0);
        checkOutput("part_err", 64'(addr_err), 64'h0);

        // Reset in the middle of a fill
        for (int a = 0; a < 4; a++) applyStimulus(1, 1, a, 32'h7700_0000 + a);
        applyStimulus(0, 1, 4, 32'h7700_0004);
        checkOutput("midfill_flags", 64'({gm_out, rd_valid, frame_full, drained, addr_err}), 64'h0);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1, 0, k, 0);
            checkOutput("midfill_rd_valid", 64'(rd_valid), 64'h0);
        end

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            if (f % 2 == 0) begin
                for (int a = 0; a < DEPTH; a++) applyStimulus(1, 1, a, $urandom);
            end
            nw = $urandom_range(1, 10);
            for (int i = 0; i < nw; i++) applyStimulus(1, 1, $urandom_range(0, 9), $urandom);
            nr = $urandom_range(4, 16);
            for (int i = 0; i < nr; i++) begin
                if ($urandom_range(0, 39) == 0) applyStimulus(0, 0, 0, 0);
                else applyStimulus(1, 0, $urandom_range(0, 9), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
